aiv_capture_sequencer: RTL and testbench
========================================

// Module: aiv_capture_sequencer
// PURPOSE
//  Sequences capture of regenerated-sync AIV RGB111 video into a double-banked line buffer.
//  Counts pixels and lines from the PAL 576i hsync/vsync/isFieldOdd timing, and gates
//  per-pixel write strobes and addresses into the capture window.
//  Hands each completed line to the SCART readout side with a valid/ack bank handshake.
//  Sits between sync_regenerator_pal576i and the line-buffer RAM, in the pixelClockX6 domain.
// PARAMETERS
//  H_START   140  pixelEn ticks from the hsync edge to the first captured pixel
//  H_ACTIVE  640  pixels captured per line
//  V_START   23   hsync edges after the vsync edge before the first captured line
//  V_ACTIVE  288  lines captured per field
//  ADDR_W    10   line-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE
//  LINE_W    9    line-index width
// PORTS
//  sysClock     in   1       pixelClockX6 clock; all logic on its rising edge
//  nReset       in   1       asynchronous active-low reset
//  pixelEn      in   1       pixel-rate enable (pixelClockX1_en)
//  hsync        in   1       line sync pulse; rising edge used
//  vsync        in   1       field sync pulse; rising edge used
//  isFieldOdd   in   1       field parity from the sync regenerator
//  enable       in   1       capture enable
//  bankAck      in   1       reader has finished with readyBank (1-cycle pulse)
//  wrEn         out  1       line-buffer write strobe
//  wrAddr       out  ADDR_W  pixel address within the bank
//  wrBank       out  1       bank being written
//  readyValid   out  1       completed line available
//  readyBank    out  1       bank holding that line
//  readyLine    out  LINE_W  active-line index of that line (0..V_ACTIVE-1)
//  readyField   out  1       field parity of that line
//  overrunCnt   out  8       lines dropped, saturating at 255
//  truncFlag    out  1       sticky: a line was aborted by early hsync or vsync
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; pixel and line counters 0.
//  Edge detect: hsync and vsync are registered and rise-detected every sysClock, independent of pixelEn.
//  vsync edge: lineCnt<=0; latch isFieldOdd; any capture in progress aborts (truncFlag<=1); go to WAIT_V.
//  hsync edge: pixCnt<=0; lineCnt<=lineCnt+1, saturating at all-ones.
//  pixCnt: increments on pixelEn and saturates.
//  States:
//   IDLE: no writes. Leaves to WAIT_V on a vsync edge while enable=1.
//   WAIT_V: on an hsync edge where the new lineCnt is in [V_START, V_START+V_ACTIVE-1], go to WAIT_H.
//   WAIT_H: when pixelEn and pixCnt==H_START, go to CAPT.
//   CAPT: on each pixelEn with pixCnt in [H_START, H_START+H_ACTIVE-1]:
//    - next cycle: wrEn=1 for exactly one cycle, wrAddr=pixCnt-H_START, wrBank=current write bank.
//    - after the write with wrAddr=H_ACTIVE-1, go to DONE.
//    - hsync edge in CAPT before the last pixel: abort the line, truncFlag<=1, go to WAIT_V.
//   DONE (one cycle):
//    - readyValid=0: set readyValid=1, readyBank=wrBank, readyLine=lineCnt-V_START,
//      readyField=latched parity; toggle wrBank.
//    - readyValid=1: drop the line, overrunCnt+1 (saturating), keep wrBank.
//    - then go to WAIT_V, or to IDLE if lineCnt-V_START == V_ACTIVE-1.
//  Latency: readyValid rises 2 cycles after the final wrEn.
//  Handshake:
//   - readyValid/readyBank/readyLine/readyField stay stable until bankAck is sampled with readyValid=1.
//   - readyValid clears the next cycle.
//   - bankAck while readyValid=0 is ignored.
//   - The writer never writes readyBank while readyValid=1.
//  Simultaneous events:
//   - DONE and bankAck in the same cycle: the ack is processed first, so the new line is accepted.
//   - vsync and hsync edges in the same cycle: vsync wins; lineCnt<=0.
//  enable=0: go to IDLE the next cycle; wrEn=0 from that cycle; a pending readyValid is held until acked.
//  nReset mid-line: immediate return to the reset state; the partial line is discarded.
// TESTING
//  - Field, enable=1, bankAck pulsed 10 cycles after each readyValid -> 288 readyValid pulses,
//    readyLine 0..287, wrBank alternating, 640 wrEn per line, wrAddr 0..639.
//  - First captured pixel -> wrEn rises 1 cycle after the pixelEn where pixCnt==140,
//    with wrAddr=0; wrAddr=639 occurs at pixCnt==779.
//  - Never ack -> line 0 ready in bank 0; lines 1..287 dropped; overrunCnt=255 (saturated);
//    no wrEn to bank 0.
//  - hsync edge injected at pixCnt==400 -> truncFlag=1, no readyValid for that line,
//    capture resumes on the next line.
//  - enable deasserted mid-CAPT, with readyValid pending -> wrEn=0 from the next cycle;
//    readyValid held until bankAck, then 0.
//  - nReset pulsed low mid-CAPT -> all outputs 0 immediately; capture resumes only after the next vsync edge.

Source files
------------

// File: rtl/aiv_capture_sequencer.sv
// Capture sequencer for regenerated-sync AIV RGB111 video into a double-banked line buffer.
// Counts pixels/lines from PAL 576i sync and hands finished lines to the SCART reader.
//
// state  | meaning
// IDLE   | capture off, waiting for a field start with enable high
// WAIT_V | waiting for an hsync edge that opens a line inside the vertical window
// WAIT_H | line selected, waiting for the first horizontal pixel
// CAPT   | writing pixels of the current line
// DONE   | line complete, publish it to the reader or count it as dropped
module aiv_capture_sequencer #(
    parameter int H_START  = 140,
    parameter int H_ACTIVE = 640,
    parameter int V_START  = 23,
    parameter int V_ACTIVE = 288,
    parameter int ADDR_W   = 10,
    parameter int LINE_W   = 9
) (
    input  logic              sysClock,
    input  logic              nReset,
    input  logic              pixelEn,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              isFieldOdd,
    input  logic              enable,
    input  logic              bankAck,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic              wrBank,
    output logic              readyValid,
    output logic              readyBank,
    output logic [LINE_W-1:0] readyLine,
    output logic              readyField,
    output logic [7:0]        overrunCnt,
    output logic              truncFlag
);

    localparam int PIX_W = $clog2(H_START + H_ACTIVE + 1) + 1;
    localparam logic [PIX_W-1:0]  PIX_FIRST  = PIX_W'(H_START);
    localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(H_START + H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(H_ACTIVE - 1);
    localparam logic [LINE_W-1:0] LINE_FIRST = LINE_W'(V_START);
    localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(V_START + V_ACTIVE - 1);
    localparam logic [LINE_W-1:0] IDX_LAST   = LINE_W'(V_ACTIVE - 1);

    typedef enum logic [2:0] {IDLE, WAIT_V, WAIT_H, CAPT, DONE} state_t;

    state_t             state;
    logic               hsyncPrev;
    logic               vsyncPrev;
    logic [PIX_W-1:0]   pixCnt;
    logic [LINE_W-1:0]  lineCnt;
    logic               fieldOdd;

    logic               hsEdge;
    logic               vsEdge;
    logic [LINE_W-1:0]  lineNext;
    logic [LINE_W-1:0]  lineIdx;
    logic               lineInRange;
    logic               pixInRange;

    always_comb begin
        hsEdge      = hsync & ~hsyncPrev;
        vsEdge      = vsync & ~vsyncPrev;
        lineNext    = (&lineCnt) ? lineCnt : lineCnt + LINE_W'(1);
        lineIdx     = lineCnt - LINE_FIRST;
        lineInRange = (lineNext >= LINE_FIRST) && (lineNext <= LINE_LAST);
        pixInRange  = (pixCnt >= PIX_FIRST) && (pixCnt <= PIX_LAST);
    end

    always_ff @(posedge sysClock or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            hsyncPrev  <= 1'b0;
            vsyncPrev  <= 1'b0;
            pixCnt     <= '0;
            lineCnt    <= '0;
            fieldOdd   <= 1'b0;
            wrEn       <= 1'b0;
            wrAddr     <= '0;
            wrBank     <= 1'b0;
            readyValid <= 1'b0;
            readyBank  <= 1'b0;
            readyLine  <= '0;
            readyField <= 1'b0;
            overrunCnt <= '0;
            truncFlag  <= 1'b0;
        end else begin
            hsyncPrev <= hsync;
            vsyncPrev <= vsync;

            if (vsEdge)
                lineCnt <= '0;
            else if (hsEdge)
                lineCnt <= lineNext;

            if (hsEdge)
                pixCnt <= '0;
            else if (pixelEn && !(&pixCnt))
                pixCnt <= pixCnt + PIX_W'(1);

            if (vsEdge)
                fieldOdd <= isFieldOdd;

            wrEn <= 1'b0;

            // The ack is applied first so a DONE in the same cycle sees a free slot.
            if (readyValid && bankAck)
                readyValid <= 1'b0;

            if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (vsEdge)
                            state <= WAIT_V;
                    end
                    WAIT_V: begin
                        if (!vsEdge && hsEdge && lineInRange)
                            state <= WAIT_H;
                    end
                    WAIT_H: begin
                        if (vsEdge) begin
                            state <= WAIT_V;
                        end else if (hsEdge) begin
                            state <= lineInRange ? WAIT_H : WAIT_V;
                        end else if (pixelEn && pixCnt == PIX_FIRST) begin
                            wrEn   <= 1'b1;
                            wrAddr <= '0;
                            state  <= CAPT;
                        end
                    end
                    CAPT: begin
                        // Leave only once the last write has actually been presented.
                        if (wrEn && wrAddr == ADDR_LAST) begin
                            state <= DONE;
                        end else if (vsEdge || hsEdge) begin
                            truncFlag <= 1'b1;
                            state     <= WAIT_V;
                        end else if (pixelEn && pixInRange) begin
                            wrEn   <= 1'b1;
                            wrAddr <= ADDR_W'(pixCnt - PIX_FIRST);
                        end
                    end
                    DONE: begin
                        if (readyValid && !bankAck) begin
                            if (overrunCnt != 8'hFF)
                                overrunCnt <= overrunCnt + 8'd1;
                        end else begin
                            readyValid <= 1'b1;
                            readyBank  <= wrBank;
                            readyLine  <= lineIdx;
                            readyField <= fieldOdd;
                            wrBank     <= ~wrBank;
                        end
                        state <= (!vsEdge && lineIdx == IDX_LAST) ? IDLE : WAIT_V;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aiv_capture_sequencer.sv
// Scoreboard bench for aiv_capture_sequencer: stimulus queues expected writes and ready
// lines, a monitor pops and compares them as the DUT presents them.
module tb_aiv_capture_sequencer;

    localparam int H_START  = 5;
    localparam int H_ACTIVE = 12;
    localparam int V_START  = 3;
    localparam int V_ACTIVE = 288;
    localparam int ADDR_W   = 4;
    localparam int LINE_W   = 9;
    localparam int P_TOTAL  = H_START + H_ACTIVE + 4;

    logic              sysClock = 1'b0;
    logic              nReset = 1'b0;
    logic              pixelEn = 1'b0;
    logic              hsync = 1'b0;
    logic              vsync = 1'b0;
    logic              isFieldOdd = 1'b0;
    logic              enable = 1'b0;
    logic              bankAck = 1'b0;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic              wrBank;
    logic              readyValid;
    logic              readyBank;
    logic [LINE_W-1:0] readyLine;
    logic              readyField;
    logic [7:0]        overrunCnt;
    logic              truncFlag;

    aiv_capture_sequencer #(
        .H_START(H_START), .H_ACTIVE(H_ACTIVE), .V_START(V_START),
        .V_ACTIVE(V_ACTIVE), .ADDR_W(ADDR_W), .LINE_W(LINE_W)
    ) dut (
        .sysClock(sysClock), .nReset(nReset), .pixelEn(pixelEn), .hsync(hsync),
        .vsync(vsync), .isFieldOdd(isFieldOdd), .enable(enable), .bankAck(bankAck),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrBank(wrBank), .readyValid(readyValid),
        .readyBank(readyBank), .readyLine(readyLine), .readyField(readyField),
        .overrunCnt(overrunCnt), .truncFlag(truncFlag)
    );

    initial forever #5 sysClock = ~sysClock;

    typedef struct {int addr; int bank;} wr_t;
    typedef struct {int line; int bank; int field;} rdy_t;

    wr_t  wrQ[$];
    rdy_t rdyQ[$];
    int   checks = 0;
    int   errors = 0;
    bit   autoAck = 1'b0;
    int   ackReqCnt = 0;
    int   ackDoneCnt = 0;
    int   ackCnt = 0;

    int   pcModel = 0;
    int   enPc = -1;
    bit   hsModelPrev = 1'b0;
    int   sampleIdx = 0;
    int   lastWrIdx = -100;
    bit   rvPrev = 1'b0;
    logic [31:0] heldReady = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chkZero(input string name);
        chk(name, 32'({wrEn, wrAddr, wrBank, readyValid, readyBank, readyLine,
                       readyField, overrunCnt, truncFlag}), 32'd0);
    endtask

    task automatic pushLine(input int idx, input int bank, input int field, input int nWr, input bit rdy);
        for (int a = 0; a < nWr; a++) wrQ.push_back('{addr: a, bank: bank});
        if (rdy) rdyQ.push_back('{line: idx, bank: bank, field: field});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysClock);
    endtask

    task automatic vsPulse();
        @(negedge sysClock); vsync = 1'b1;
        @(negedge sysClock); vsync = 1'b0;
        idle(2);
    endtask

    // One video line: hsync pulse then P_TOTAL pixels with pixelEn every other cycle.
    task automatic line(input int abortAt, input int disableAt, input int resetAt);
        @(negedge sysClock); hsync = 1'b1; pixelEn = 1'b0;
        @(negedge sysClock); hsync = 1'b0;
        for (int p = 0; p < P_TOTAL; p++) begin
            @(negedge sysClock);
            pixelEn = 1'b1;
            if (p == abortAt) hsync = 1'b1;
            if (p == disableAt) enable = 1'b0;
            @(negedge sysClock);
            pixelEn = 1'b0;
            hsync = 1'b0;
            if (p == resetAt) begin
                #2 nReset = 1'b0;
                #1 chkZero("reset_mid_capt");
            end
        end
        nReset = 1'b1;
    endtask

    // Reader side: acks automatically 10 cycles after readyValid, or once on request.
    initial forever begin
        @(negedge sysClock);
        if (bankAck) begin
            bankAck = 1'b0;
        end else if (ackReqCnt != ackDoneCnt) begin
            bankAck = 1'b1;
            ackDoneCnt = ackReqCnt;
        end else if (autoAck && readyValid) begin
            ackCnt++;
            if (ackCnt == 10) begin
                bankAck = 1'b1;
                ackCnt = 0;
            end
        end else begin
            ackCnt = 0;
        end
    end

    // Monitor: samples 1 time unit after each rising edge.
    initial forever begin
        @(posedge sysClock);
        #1;
        sampleIdx++;
        if (!nReset) begin
            pcModel = 0;
            enPc = -1;
            hsModelPrev = 1'b0;
        end else begin
            if (hsync && !hsModelPrev) begin
                pcModel = 0;
                enPc = -1;
            end else if (pixelEn) begin
                enPc = pcModel;
                pcModel++;
            end else begin
                enPc = -1;
            end
            hsModelPrev = hsync;
        end

        if (wrEn) begin
            chk("wr_timing", 32'(int'(wrAddr) + H_START), 32'(enPc));
            chk("wr_not_ready_bank", 32'(rvPrev && (wrBank == readyBank)), 32'd0);
            chk("wr_queue_nonempty", 32'(wrQ.size() > 0), 32'd1);
            if (wrQ.size() > 0) begin
                wr_t w;
                w = wrQ.pop_front();
                chk("wr_addr", 32'(wrAddr), 32'(w.addr));
                chk("wr_bank", 32'(wrBank), 32'(w.bank));
            end
            lastWrIdx = sampleIdx;
        end

        if (readyValid && !rvPrev) begin
            chk("rdy_queue_nonempty", 32'(rdyQ.size() > 0), 32'd1);
            if (rdyQ.size() > 0) begin
                rdy_t r;
                r = rdyQ.pop_front();
                chk("rdy_line", 32'(readyLine), 32'(r.line));
                chk("rdy_bank", 32'(readyBank), 32'(r.bank));
                chk("rdy_field", 32'(readyField), 32'(r.field));
            end
            chk("rdy_latency", 32'(sampleIdx - lastWrIdx), 32'd2);
            heldReady = 32'({readyBank, readyLine, readyField});
        end else if (readyValid && rvPrev) begin
            chk("rdy_stable", 32'({readyBank, readyLine, readyField}), heldReady);
        end

        if (bankAck && rvPrev)
            chk("ack_clears", 32'(readyValid), 32'd0);
        rvPrev = readyValid;
    end

    initial begin
        enable = 1'b1;
        nReset = 1'b0;
        idle(3);
        chkZero("reset_outputs");
        nReset = 1'b1;

        // Full field with the reader acking every line.
        autoAck = 1'b1;
        isFieldOdd = 1'b1;
        vsPulse();
        for (int k = 1; k <= V_START + V_ACTIVE; k++) begin
            if (k >= V_START && k <= V_START + V_ACTIVE - 1)
                pushLine(k - V_START, (k - V_START) % 2, 1, H_ACTIVE, 1'b1);
            line(-1, -1, -1);
        end
        idle(40);
        chk("field_queues_empty", 32'(wrQ.size() + rdyQ.size()), 32'd0);
        chk("field_no_overrun", 32'(overrunCnt), 32'd0);
        chk("field_no_trunc", 32'(truncFlag), 32'd0);

        // Reader never acks: line 0 held in bank 0, the rest land in bank 1 and drop.
        autoAck = 1'b0;
        isFieldOdd = 1'b0;
        vsPulse();
        for (int k = 1; k <= V_START + V_ACTIVE; k++) begin
            if (k == V_START)
                pushLine(0, 0, 0, H_ACTIVE, 1'b1);
            else if (k > V_START && k <= V_START + V_ACTIVE - 1)
                pushLine(k - V_START, 1, 0, H_ACTIVE, 1'b0);
            line(-1, -1, -1);
        end
        chk("noack_overrun_sat", 32'(overrunCnt), 32'd255);
        chk("noack_valid_held", 32'(readyValid), 32'd1);
        chk("noack_line0", 32'(readyLine), 32'd0);
        chk("noack_bank0", 32'(readyBank), 32'd0);
        ackReqCnt++;
        idle(5);
        chk("noack_cleared", 32'(readyValid), 32'd0);

        @(negedge sysClock); nReset = 1'b0;
        #1 chkZero("reset_after_overrun");
        @(negedge sysClock); nReset = 1'b1;

        // Early hsync in the middle of a captured line.
        autoAck = 1'b1;
        isFieldOdd = 1'b1;
        vsPulse();
        line(-1, -1, -1);
        line(-1, -1, -1);
        pushLine(0, 0, 1, H_ACTIVE, 1'b1);
        line(-1, -1, -1);
        chk("trunc_before", 32'(truncFlag), 32'd0);
        pushLine(1, 1, 1, 4, 1'b0);
        line(H_START + 4, -1, -1);
        chk("trunc_after", 32'(truncFlag), 32'd1);
        pushLine(3, 1, 1, H_ACTIVE, 1'b1);
        line(-1, -1, -1);
        pushLine(4, 0, 1, H_ACTIVE, 1'b1);
        line(-1, -1, -1);
        idle(30);

        // enable drops mid-line while an unacked line is pending.
        autoAck = 1'b0;
        pushLine(5, 1, 1, H_ACTIVE, 1'b1);
        line(-1, -1, -1);
        pushLine(6, 0, 1, 6, 1'b0);
        line(-1, H_START + 6, -1);
        line(-1, -1, -1);
        chk("disable_valid_held", 32'(readyValid), 32'd1);
        chk("disable_line", 32'(readyLine), 32'd5);
        chk("disable_bank", 32'(readyBank), 32'd1);
        ackReqCnt++;
        idle(5);
        chk("disable_acked", 32'(readyValid), 32'd0);
        enable = 1'b1;

        // Reset mid-line; capture restarts only after a fresh vsync.
        autoAck = 1'b1;
        line(-1, -1, -1);
        vsPulse();
        line(-1, -1, -1);
        line(-1, -1, -1);
        pushLine(0, 0, 1, 4, 1'b0);
        line(-1, -1, H_START + 3);
        line(-1, -1, -1);
        line(-1, -1, -1);
        line(-1, -1, -1);
        isFieldOdd = 1'b0;
        vsPulse();
        line(-1, -1, -1);
        line(-1, -1, -1);
        pushLine(0, 0, 0, H_ACTIVE, 1'b1);
        line(-1, -1, -1);
        idle(40);
        chk("final_wr_queue_empty", 32'(wrQ.size()), 32'd0);
        chk("final_rdy_queue_empty", 32'(rdyQ.size()), 32'd0);
        chk("final_valid_clear", 32'(readyValid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
